// File: rtl/uart_tx_fifo.sv
// Byte FIFO that queues host writes and launches them one at a time into a UART
// transmitter, waiting for tx_done between launches.
module uart_tx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_active,
   input  logic              tx_done
);

   typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

   localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CntOne   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CntDepth = (ADDR_W+1)'(DEPTH);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                overflow_q, overflow_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic [7:0]          mem_q [DEPTH];

   logic push;
   logic pop;

   // full is the registered flag, so a write when full is dropped even if a pop
   // frees a slot on the same edge.
   assign push = wr_en & ~full_q & ~flush;
   assign pop  = (state_q == StIdle) & ~empty_q & ~tx_active & ~flush;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      overflow_d = wr_en & full_q & ~flush;

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               tx_start_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
               state_d    = StWaitDone;
            end
         end
         StWaitDone: begin
            if (tx_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end

      full_d  = (count_d == CntDepth);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small UART model answers each tx_start with
// tx_done after a programmable delay; launched bytes are checked against a scoreboard.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              flush;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_active;
   logic              tx_done;

   uart_tx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_active (tx_active),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] sb [$];
   int         cyc        = 0;
   int         last_done  = -1;
   int         n_starts   = 0;
   int         lat        = 3;
   int         cnt        = 0;
   bit         hold       = 1'b0;
   bit         inflight   = 1'b0;
   bit         check_gap  = 1'b0;
   logic [7:0] held       = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample outputs and run the UART model.
   task automatic tick();
      bit started;
      @(posedge clk);
      #1;
      cyc++;
      started = 1'b0;
      if (tx_done) begin
         last_done = cyc;
         tx_done   = 1'b0;
         tx_active = 1'b0;
      end
      if (tx_start) begin
         started = 1'b1;
         n_starts++;
         chk("start_while_busy", {31'b0, inflight}, 32'd0);
         chk("start_expected", {31'b0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            chk("tx_data", {24'b0, tx_data}, {24'b0, sb.pop_front()});
         end
         if (check_gap && last_done >= 0) begin
            chk("done_to_start_gap", cyc - last_done, 32'd1);
         end
         inflight  = 1'b1;
         held      = tx_data;
         cnt       = lat;
         tx_active = 1'b1;
      end else if (inflight) begin
         chk("tx_data_hold", {24'b0, tx_data}, {24'b0, held});
      end
      if (inflight && !started && !hold) begin
         cnt--;
         if (cnt <= 0) begin
            tx_done  = 1'b1;
            inflight = 1'b0;
         end
      end
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((inflight || tx_done || sb.size() != 0) && n < max) begin
         tick();
         n++;
      end
      chk("drain_timeout", {31'b0, n < max}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [7:0] hello [5];
      logic [7:0] b;
      hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

      reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
      tx_active = 1'b0; tx_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("rst_count", {27'b0, count}, 32'd0);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);

      // Single byte latency: written at edge k, launched at edge k+1.
      lat = 5;
      sb.push_back(8'h48);
      wr(8'h48);
      chk("lat_empty_after_write", {31'b0, empty}, 32'd0);
      chk("lat_count_after_write", {27'b0, count}, 32'd1);
      chk("lat_no_start_yet", {31'b0, tx_start}, 32'd0);
      tick();
      chk("lat_start", {31'b0, tx_start}, 32'd1);
      chk("lat_count_after_pop", {27'b0, count}, 32'd0);
      chk("lat_empty_after_pop", {31'b0, empty}, 32'd1);
      tick();
      chk("lat_start_one_cycle", {31'b0, tx_start}, 32'd0);
      wait_idle(50);

      // "Hello" burst with a slow transmitter.
      lat = 100; last_done = -1; check_gap = 1'b1; s0 = n_starts;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(hello[i]);
         wr(hello[i]);
         if (i == 1) chk("hello_write_and_pop_count", {27'b0, count}, 32'd1);
      end
      wait_idle(1000);
      chk("hello_starts", n_starts - s0, 32'd5);
      check_gap = 1'b0;

      // Fill with tx_done held low, then overflow.
      lat = 3; hold = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         sb.push_back(8'(i));
         wr(8'(i));
         chk("fill_no_overflow", {31'b0, overflow}, 32'd0);
      end
      chk("fill_full", {31'b0, full}, 32'd1);
      chk("fill_count", {27'b0, count}, 32'd16);
      chk("fill_not_empty", {31'b0, empty}, 32'd0);
      wr(8'hAA);
      chk("ovf_pulse", {31'b0, overflow}, 32'd1);
      chk("ovf_count", {27'b0, count}, 32'd16);
      tick();
      chk("ovf_one_cycle", {31'b0, overflow}, 32'd0);
      hold = 1'b0;
      wait_idle(400);
      chk("fill_drained_empty", {31'b0, empty}, 32'd1);

      // 40 bytes in bursts of 10 so the pointers wrap repeatedly.
      lat = 2; s0 = n_starts;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            sb.push_back(b);
            wr(b);
         end
         wait_idle(200);
      end
      chk("wrap_starts", n_starts - s0, 32'd40);

      // Flush with one byte in flight and three queued; concurrent write dropped.
      lat = 4; hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(8'hA0 + 8'(i));
         wr(8'hA0 + 8'(i));
      end
      tick();
      chk("pre_flush_count", {27'b0, count}, 32'd3);
      wr_en = 1'b1; wr_data = 8'h55; flush = 1'b1;
      sb.delete();
      tick();
      wr_en = 1'b0; flush = 1'b0;
      chk("flush_count", {27'b0, count}, 32'd0);
      chk("flush_empty", {31'b0, empty}, 32'd1);
      chk("flush_no_overflow", {31'b0, overflow}, 32'd0);
      s0 = n_starts;
      hold = 1'b0;
      wait_idle(100);
      repeat (20) tick();
      chk("flush_no_more_starts", n_starts - s0, 32'd0);
      chk("flush_still_empty", {31'b0, empty}, 32'd1);

      // Asynchronous reset during WAIT_DONE with two bytes queued.
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(8'hB0 + 8'(i));
         wr(8'hB0 + 8'(i));
      end
      tick();
      chk("pre_reset_count", {27'b0, count}, 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_count", {27'b0, count}, 32'd0);
      chk("arst_empty", {31'b0, empty}, 32'd1);
      chk("arst_full", {31'b0, full}, 32'd0);
      chk("arst_tx_start", {31'b0, tx_start}, 32'd0);
      chk("arst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("arst_overflow", {31'b0, overflow}, 32'd0);
      sb.delete(); inflight = 1'b0; hold = 1'b0; tx_active = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      s0 = n_starts;
      tx_done = 1'b1;
      tick();
      repeat (10) tick();
      chk("post_reset_no_start", n_starts - s0, 32'd0);
      chk("post_reset_count", {27'b0, count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO and launch sequencer that sits directly upstream of uart_full_duplex. It accepts bursts of bytes from a host and holds them. It feeds the UART transmitter one byte at a time through tx_start/tx_data, and waits for tx_done before launching the next byte. Back-to-back writes such as a full "Hello" string are therefore never lost or overwritten while the transmitter is busy.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
wr_en  input  1  host write strobe, one byte per cycle
wr_data  input  8  host write byte
flush  input  1  synchronous clear of queued (not yet launched) bytes
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  number of queued entries, 0..DEPTH
overflow  output  1  one-cycle pulse when a write is dropped
tx_start  output  1  one-cycle launch pulse to UART transmitter
tx_data  output  8  byte to transmit; stable from tx_start until tx_done
tx_active  input  1  UART transmitter busy
tx_done  input  1  UART transmitter one-cycle completion pulse

Behaviour:
- Reset (reset_n low, asynchronous):
  - pointers=0, count=0, full=0, empty=1, overflow=0
  - tx_start=0, tx_data=8'h00, FSM=IDLE
  - storage array is not reset.
- Write:
  - wr_en & !full & !flush at an edge stores wr_data at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
  - wr_en & full: byte dropped, overflow=1 for the next cycle, no state change.
  - A write when full is dropped even if a pop occurs on the same edge. full is evaluated before the pop.
- count/full/empty are registered and consistent with the pointers after every edge.
  - Simultaneous write and pop: count unchanged.
- FSM states: IDLE, WAIT_DONE.
  - IDLE:
    - if !empty & !tx_active & !flush: pop mem[rd_ptr] into tx_data, rd_ptr++, tx_start=1 for exactly one cycle, go to WAIT_DONE.
    - otherwise stay in IDLE; tx_start=0.
  - WAIT_DONE:
    - tx_start=0; tx_data held.
    - on tx_done=1, go to IDLE. The next pop may occur on the following edge at the earliest.
  - tx_done seen in IDLE is ignored.
- Latency into an empty FIFO with the UART idle:
  - write sampled at edge k -> empty=0 after edge k
  - pop at edge k+1 -> tx_start high during the cycle after edge k+1.
- Inter-byte gap: after tx_done is sampled at edge m, the FSM is in IDLE. The next tx_start is high after edge m+1, provided the FIFO is non-empty and tx_active=0.
- Flush:
  - flush=1 at an edge sets rd_ptr=wr_ptr=0, count=0, empty=1, full=0.
  - A wr_en on the same edge is dropped; overflow is not asserted.
  - A byte already launched (FSM in WAIT_DONE) is not aborted; FSM still waits for tx_done.
  - flush in IDLE blocks a pop on that edge.
- Reset mid-transfer: everything returns to reset values immediately. An in-flight byte is abandoned; a later tx_done is ignored in IDLE.
- Wrap-around: pointers are ADDR_W bits and wrap naturally. full/empty are derived from count, not from pointer equality.

Test Plan:
- Reset, then write 8'h48 with the UART idle -> tx_start pulses 1 cycle two edges later with tx_data=8'h48; count returns to 0; empty=1.
- Write 48,65,6C,6C,6F on 5 consecutive cycles; model tx_done 100 cycles after each tx_start -> exactly 5 tx_start pulses in order H,e,l,l,o. Each pulse follows the previous tx_done by 1 cycle. tx_data stays stable between a tx_start and its tx_done.
- Hold tx_done low and write 17 bytes 0x00..0x10 (DEPTH=16):
  - the first byte launches, bytes 0x01..0x10 fill the FIFO
  - full=1, count=16, no overflow
  - an 18th write of 0xAA -> overflow pulse, 0xAA never transmitted.
- Keep the FIFO draining for 40 bytes with DEPTH=16 -> pointers wrap twice and the output sequence equals the input sequence.
- With 3 bytes queued and one byte in WAIT_DONE, assert flush together with wr_en=1 (0x55) -> count=0, 0x55 dropped, overflow=0. The in-flight byte completes on tx_done and no further tx_start occurs.
- Assert reset_n low during WAIT_DONE with 2 bytes queued -> all outputs return to reset values asynchronously; a subsequent tx_done produces no tx_start.
